// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and result bundle for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Packed result for consumers that move sum and flags as one word.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] s;
        logic                 co;
        logic                 ov;
        logic                 zero;
    } addsub_result_t;

    // Pipeline depth for a given operand width and segment size.
    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Request/result channels of the pipelined adder/subtractor.
// The master offers operations and consumes results; the slave is the adder.
interface pipelined_addsub_if #(
    parameter int WIDTH = pipelined_addsub_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    logic             zero;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ov, zero
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ov, zero
    );
endinterface

// File: rtl/pipelined_addsub_add_chunk.sv
// Combinational CHUNK-bit ripple adder segment. Also exposes the carry into
// its top bit so the last segment can form the signed-overflow flag.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             ctop
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
        assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end

    assign cout = c[CHUNK];
    assign ctop = c[CHUNK-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple segment per
// stage, carry handed stage to stage, upper operand bits skewed alongside.
// WIDTH must be >= 2 and a multiple of CHUNK.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    // Inter-stage registers sit between segments; a single-stage build keeps
    // a one-entry array that is never loaded.
    localparam int PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;

    // Inter-stage registers. Operands are stored pre-shifted so every stage
    // always sums the low CHUNK bits; partial sums enter at the top and shift
    // down, so after the last stage chunk 0 lands at bit 0.
    logic [WIDTH-1:0] a_reg   [PIPE];
    logic [WIDTH-1:0] b_reg   [PIPE];
    logic [WIDTH-1:0] sum_reg [PIPE];
    logic [PIPE-1:0]  carry_reg;
    logic [PIPE-1:0]  valid_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] s_reg;
    logic             co_reg;
    logic             ov_reg;
    logic             zero_reg;

    // Per-stage combinational view.
    logic [WIDTH-1:0] a_in     [STAGES];
    logic [WIDTH-1:0] b_in     [STAGES];
    logic [WIDTH-1:0] sum_prev [STAGES];
    logic [WIDTH-1:0] sum_next [STAGES];
    logic [CHUNK-1:0] sum_c    [STAGES];
    logic             ctop_c   [STAGES];
    logic [STAGES-1:0] cin_c;
    logic [STAGES-1:0] cout_c;
    logic [STAGES-1:0] v_in;

    // Subtraction as a + ~b + ~borrow.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c_in  = bus.sub ? ~bus.ci : bus.ci;

    // Whole pipeline moves together; a free or draining output slot lets it advance.
    assign adv          = ~out_valid_reg | bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_entry
            assign a_in[gi]     = bus.a;
            assign b_in[gi]     = b_eff;
            assign cin_c[gi]    = c_in;
            assign v_in[gi]     = bus.in_valid;
            assign sum_prev[gi] = '0;
        end else begin : g_inner
            assign a_in[gi]     = a_reg[gi-1];
            assign b_in[gi]     = b_reg[gi-1];
            assign cin_c[gi]    = carry_reg[gi-1];
            assign v_in[gi]     = valid_reg[gi-1];
            assign sum_prev[gi] = sum_reg[gi-1];
        end

        add_chunk #(.CHUNK(CHUNK)) u_add (
            .x    (a_in[gi][CHUNK-1:0]),
            .y    (b_in[gi][CHUNK-1:0]),
            .cin  (cin_c[gi]),
            .sum  (sum_c[gi]),
            .cout (cout_c[gi]),
            .ctop (ctop_c[gi])
        );

        assign sum_next[gi] = (WIDTH'(sum_c[gi]) << (WIDTH - CHUNK)) | (sum_prev[gi] >> CHUNK);
    end

    // Shift every stage forward on advance; reset flushes all in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE; k++) begin
                a_reg[k]   <= '0;
                b_reg[k]   <= '0;
                sum_reg[k] <= '0;
            end
            carry_reg     <= '0;
            valid_reg     <= '0;
            out_valid_reg <= 1'b0;
            s_reg         <= '0;
            co_reg        <= 1'b0;
            ov_reg        <= 1'b0;
            zero_reg      <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_reg[k]     <= a_in[k] >> CHUNK;
                b_reg[k]     <= b_in[k] >> CHUNK;
                sum_reg[k]   <= sum_next[k];
                carry_reg[k] <= cout_c[k];
                valid_reg[k] <= v_in[k];
            end
            out_valid_reg <= v_in[STAGES-1];
            s_reg         <= sum_next[STAGES-1];
            co_reg        <= cout_c[STAGES-1];
            ov_reg        <= cout_c[STAGES-1] ^ ctop_c[STAGES-1];
            zero_reg      <= ~|sum_next[STAGES-1];
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.s         = s_reg;
    assign bus.co        = co_reg;
    assign bus.ov        = ov_reg;
    assign bus.zero      = zero_reg;
endmodule
